joy_dir_filter: RTL and testbench
=================================

# joy_dir_filter

Multi-player joystick direction conditioner that sits between the merged USB/DB9/DB15 joystick vectors and the game core's input ports. Per player, it synchronises and optionally debounces the four direction bits. It then applies a run-time selectable restriction mode: passthrough, 4-way last-pressed, 4-way first-held, or 8-way with opposing-direction (SOCD) resolution. It generalises the single-player, single-mode 4-way mask to N players and four modes, with deterministic fallback and tie-break rules.

## Interface
- `PLAYERS`, default 2: number of independent direction channels (1..4).
- `DEB_CYCLES`, default 0: debounce stability length in `ce` ticks; 0 bypasses debounce. Legal range is 0..255.
- `clk`, input, 1: system clock (`clk_sys` domain).
- `reset`, input, 1: synchronous, active-high reset.
- `ce`, input, 1: debounce tick enable. Sync and filter logic run every `clk`.
- `mode`, input, 2: 0 = passthrough, 1 = 4-way last-pressed, 2 = 4-way first-held, 3 = 8-way SOCD.
- `in_dir`, input, 4*PLAYERS: per player p, bits [4p+3:4p] = {up, down, left, right}, active high, asynchronous.
- `out_dir`, output, 4*PLAYERS: filtered directions, same bit order, registered.
- `dir_chg`, output, PLAYERS: one-cycle strobe, set when that player's `out_dir` nibble changes value.

## Operation
- **Sync stage.** Each `in_dir` bit passes through a 2-flop synchroniser.
- **Debounce stage** (only when `DEB_CYCLES` > 0). Each bit has an 8-bit counter.
  - On a `ce` tick, if the synced bit differs from the debounced bit, the counter increments.
  - When the counter reaches `DEB_CYCLES`, the debounced bit takes the synced value and the counter clears.
  - If the synced bit equals the debounced bit, the counter clears on any cycle.
  - The result is the clean vector `d`.
- **Per-player state.** Previous clean vector `dp` (4 bits) and active direction `act` (one-hot or 0).
  - `rise = d & ~dp`.
  - The fixed priority encoder is `pri(x)`: up > down > left > right, returning one-hot or 0.
- **Mode 0.** `out = d`.
- **Mode 1 (4-way last-pressed).**
  - If `rise` ≠ 0: `act = pri(rise)`.
  - Else if `act & d` = 0: `act = pri(d)`.
  - Otherwise `act` holds.
  - `out = act`. At most one bit is ever set.
- **Mode 2 (4-way first-held).**
  - If `act & d` = 0: `act = pri(d)`.
  - Otherwise `act` holds; new presses are ignored while `act` remains held.
  - `out = act`.
- **Mode 3 (8-way SOCD).** The up/down and left/right pairs are resolved independently.
  - Each pair tracks a last-pressed flag `lp`.
  - If exactly one bit of the pair rises, `lp` points to it.
  - If both rise in the same cycle, `lp` = up (vertical pair) or left (horizontal pair).
  - When both bits of a pair are held, only the `lp` bit is output. Otherwise the pair passes through.
  - Diagonals are allowed.
- **Mode change.** When `mode` differs from its value registered on the previous cycle, all players' `act` and `lp` clear and `dp` loads 0. The next evaluation therefore treats all currently held bits as new rises.
- **`dir_chg[p]`.** Set when the newly registered `out_dir` nibble for player p ≠ its previous value.
- **Reset.** All sync flops, debounce bits and counters, `dp`, `act`, `lp`, the registered `mode`, `out_dir` and `dir_chg` go to 0. Reset asserted mid-debounce discards the partial count.

## Timing
- **Latency with `DEB_CYCLES` = 0.** `in_dir` change to `out_dir` is 3 `clk` cycles: 2 sync flops plus 1 output register.
- **Latency with `DEB_CYCLES` = N.** Add N `ce` ticks plus 1 cycle for the debounce register.
- **`dir_chg`.** Asserts in the same cycle the new `out_dir` value is first visible and lasts exactly 1 cycle.
- **Player independence.** Players are fully independent; simultaneous events on different players do not interact.
- **Mode switch.** The switch takes effect on `out_dir` 2 cycles after `mode` changes: 1 cycle to register `mode`, 1 cycle for the output.
- **`ce` held low.** With `DEB_CYCLES` > 0, debounced values freeze. Filter state still updates from the frozen `d`, so it is stable.

## Test plan
- **Reset.** Hold `reset` 1 cycle with `in_dir` = 8'hFF. Required: `out_dir` = 0 and `dir_chg` = 0 during and after reset, until 3 cycles after release, when mode 0 gives `out_dir` = 8'hFF.
- **Mode 1, P0, no debounce.** Press right (4'b0001), then up 5 cycles later (4'b1001), then release up. Required: out = 0001 → 1000 → 0001, each change with a 1-cycle `dir_chg[0]` pulse.
- **Mode 2, P1.** Hold left (0010), add down (0110). Required: out stays 0010. Release left; required: out becomes 0100 exactly 3 cycles later.
- **Mode 3.**
  - Hold left, then add right. Required: out = right (0001).
  - Release right. Required: out = left (0010).
  - Press up+down in the same sync cycle. Required: vertical = up, with horizontal unaffected.
- **Debounce.** `DEB_CYCLES` = 4, `ce` every cycle. Glitch up high for 3 cycles. Required: no output change. Then hold 4 cycles; required: out = 1000 at cycle 2+4+1+1.
- **Mode switch.** With P0 holding up+right in mode 0 (out 1001), switch to mode 1. Required: 2 cycles later out = 1000 (priority fallback on re-evaluation) and `dir_chg[0]` pulses once.

Source files
------------

// File: rtl/joy_dir_filter.sv
// Per-player joystick direction conditioner: 2-flop sync, optional debounce,
// then a run-time selectable passthrough / 4-way / 8-way SOCD restriction.
module joy_dir_filter #(
  parameter int PLAYERS    = 2,
  parameter int DEB_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic [1:0]           mode,
  input  logic [4*PLAYERS-1:0] in_dir,
  output logic [4*PLAYERS-1:0] out_dir,
  output logic [PLAYERS-1:0]   dir_chg
);

  localparam int         W       = 4 * PLAYERS;
  localparam logic [7:0] DEB_LIM = 8'(DEB_CYCLES);

  // Fixed priority: up > down > left > right.
  function automatic logic [3:0] pri4(input logic [3:0] x);
    if (x[3])      return 4'b1000;
    else if (x[2]) return 4'b0100;
    else if (x[1]) return 4'b0010;
    else if (x[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  logic [W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [W-1:0] clean_s;
  logic [1:0]   mode_q, mode_d;
  logic         mode_chg_s;

  always_comb begin
    s1_d   = in_dir;
    s2_d   = s1_q;
    mode_d = mode;
  end

  assign mode_chg_s = (mode != mode_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      mode_q <= 2'd0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      mode_q <= mode_d;
    end
  end

  if (DEB_CYCLES > 0) begin : g_deb
    logic [W-1:0] deb_q, deb_d;
    logic [7:0]   cnt_q [W];
    logic [7:0]   cnt_d [W];

    // Transfer happens the cycle after the count reaches the limit.
    always_comb begin
      for (int i = 0; i < W; i++) begin
        deb_d[i] = deb_q[i];
        cnt_d[i] = cnt_q[i];
        if (s2_q[i] == deb_q[i]) begin
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] == DEB_LIM) begin
          deb_d[i] = s2_q[i];
          cnt_d[i] = 8'd0;
        end else if (ce) begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        deb_q <= '0;
        for (int i = 0; i < W; i++) cnt_q[i] <= 8'd0;
      end else begin
        deb_q <= deb_d;
        for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
      end
    end

    assign clean_s = deb_q;
  end else begin : g_nodeb
    logic unused_ce_s;
    assign unused_ce_s = ce;
    assign clean_s     = s2_q;
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    logic [3:0] d_s, rise_s;
    logic [3:0] dp_q, dp_d, act_q, act_d, out_q, out_d;
    logic       lpv_q, lpv_d, lph_q, lph_d, chg_q, chg_d;

    assign d_s    = clean_s[4*p +: 4];
    assign rise_s = d_s & ~dp_q;

    // lp flags: 0 selects up / left, 1 selects down / right.
    always_comb begin
      act_d = act_q;
      lpv_d = lpv_q;
      lph_d = lph_q;
      out_d = d_s;
      case (mode_q)
        2'd0: out_d = d_s;
        2'd1: begin
          if (rise_s != 4'b0000)             act_d = pri4(rise_s);
          else if ((act_q & d_s) == 4'b0000) act_d = pri4(d_s);
          else                               act_d = act_q;
          out_d = act_d;
        end
        2'd2: begin
          if ((act_q & d_s) == 4'b0000) act_d = pri4(d_s);
          else                          act_d = act_q;
          out_d = act_d;
        end
        2'd3: begin
          if (rise_s[3])      lpv_d = 1'b0;
          else if (rise_s[2]) lpv_d = 1'b1;
          else                lpv_d = lpv_q;
          if (rise_s[1])      lph_d = 1'b0;
          else if (rise_s[0]) lph_d = 1'b1;
          else                lph_d = lph_q;
          out_d[3:2] = (d_s[3] & d_s[2]) ? (lpv_d ? 2'b01 : 2'b10) : d_s[3:2];
          out_d[1:0] = (d_s[1] & d_s[0]) ? (lph_d ? 2'b01 : 2'b10) : d_s[1:0];
        end
        default: out_d = d_s;
      endcase
      chg_d = (out_d != out_q);
      // A mode switch makes every held bit look like a fresh press next cycle.
      if (mode_chg_s) begin
        dp_d  = 4'b0000;
        act_d = 4'b0000;
        lpv_d = 1'b0;
        lph_d = 1'b0;
      end else begin
        dp_d  = d_s;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        dp_q  <= 4'b0000;
        act_q <= 4'b0000;
        lpv_q <= 1'b0;
        lph_q <= 1'b0;
        out_q <= 4'b0000;
        chg_q <= 1'b0;
      end else begin
        dp_q  <= dp_d;
        act_q <= act_d;
        lpv_q <= lpv_d;
        lph_q <= lph_d;
        out_q <= out_d;
        chg_q <= chg_d;
      end
    end

    assign out_dir[4*p +: 4] = out_q;
    assign dir_chg[p]        = chg_q;
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: reset and debounce sequences, then a vector
// table whose expected outputs are checked through a due-cycle scoreboard.
module tb_joy_dir_filter;

  logic       clk = 1'b0;
  logic       reset, ce;
  logic [1:0] mode;
  logic [7:0] in_dir, out_dir;
  logic [1:0] dir_chg;
  logic [3:0] deb_in, deb_out;
  logic       deb_chg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  joy_dir_filter #(.PLAYERS(2), .DEB_CYCLES(0)) u_dut (
    .clk(clk), .reset(reset), .ce(ce), .mode(mode),
    .in_dir(in_dir), .out_dir(out_dir), .dir_chg(dir_chg)
  );

  joy_dir_filter #(.PLAYERS(1), .DEB_CYCLES(4)) u_deb (
    .clk(clk), .reset(reset), .ce(ce), .mode(2'd0),
    .in_dir(deb_in), .out_dir(deb_out), .dir_chg(deb_chg)
  );

  typedef struct packed {
    logic [1:0] md;
    logic [7:0] din;
    logic [7:0] dout;
    logic [1:0] chg;
  } vec_t;

  typedef struct {
    int         due;
    int         idx;
    logic [7:0] dout;
    logic [1:0] chg;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      chk($sformatf("vec%0d out_dir", e.idx), out_dir, e.dout);
      chk($sformatf("vec%0d dir_chg", e.idx), {6'd0, dir_chg}, {6'd0, e.chg});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [22];
    logic [7:0] cur_in;
    int         k, lat;

    vecs = '{
      '{2'd0, 8'h00, 8'h00, 2'b11},
      '{2'd1, 8'h00, 8'h00, 2'b00},
      '{2'd1, 8'h01, 8'h01, 2'b01},
      '{2'd1, 8'h09, 8'h08, 2'b01},
      '{2'd1, 8'h01, 8'h01, 2'b01},
      '{2'd2, 8'h01, 8'h01, 2'b00},
      '{2'd2, 8'h21, 8'h21, 2'b10},
      '{2'd2, 8'h61, 8'h21, 2'b00},
      '{2'd2, 8'h41, 8'h41, 2'b10},
      '{2'd2, 8'h49, 8'h41, 2'b00},
      '{2'd3, 8'h49, 8'h49, 2'b01},
      '{2'd3, 8'h02, 8'h02, 2'b11},
      '{2'd3, 8'h03, 8'h01, 2'b01},
      '{2'd3, 8'h02, 8'h02, 2'b01},
      '{2'd3, 8'h0E, 8'h0A, 2'b01},
      '{2'd3, 8'h0F, 8'h09, 2'b01},
      '{2'd3, 8'h0D, 8'h09, 2'b00},
      '{2'd3, 8'h3D, 8'h29, 2'b10},
      '{2'd0, 8'h3D, 8'h3D, 2'b11},
      '{2'd0, 8'h09, 8'h09, 2'b11},
      '{2'd1, 8'h09, 8'h08, 2'b01},
      '{2'd1, 8'h81, 8'h81, 2'b11}
    };

    reset  = 1'b1;
    ce     = 1'b1;
    mode   = 2'd0;
    in_dir = 8'hFF;
    deb_in = 4'h0;

    // Reset: outputs stay clear until the input has crossed sync + output regs.
    @(negedge clk);
    chk("reset out_dir", out_dir, 8'h00);
    chk("reset dir_chg", {6'd0, dir_chg}, 8'h00);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post-reset out_dir", out_dir, 8'h00);
      chk("post-reset dir_chg", {6'd0, dir_chg}, 8'h00);
    end
    @(negedge clk);
    chk("release out_dir", out_dir, 8'hFF);
    chk("release dir_chg", {6'd0, dir_chg}, 8'h03);
    @(negedge clk);
    chk("release chg pulse", {6'd0, dir_chg}, 8'h00);

    // Debounce: a 3-cycle glitch must be swallowed.
    @(posedge clk); #1;
    deb_in = 4'b1000;
    repeat (3) @(posedge clk);
    #1 deb_in = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("deb glitch out", {4'd0, deb_out}, 8'h00);
      chk("deb glitch chg", {7'd0, deb_chg}, 8'h00);
    end

    // Debounce: a held press appears 2+4+1+1 cycles later.
    @(posedge clk); #1;
    deb_in = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("deb hold out c%0d", i), {4'd0, deb_out}, (i >= 8) ? 8'h08 : 8'h00);
      chk($sformatf("deb hold chg c%0d", i), {7'd0, deb_chg}, (i == 8) ? 8'h01 : 8'h00);
    end

    cur_in = in_dir;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      k      = cyc;
      lat    = (vecs[i].din != cur_in) ? 3 : 2;
      mode   = vecs[i].md;
      in_dir = vecs[i].din;
      cur_in = vecs[i].din;
      sb_q.push_back('{due: k + lat, idx: i, dout: vecs[i].dout, chg: vecs[i].chg});
      sb_q.push_back('{due: k + 5,   idx: i, dout: vecs[i].dout, chg: 2'b00});
      repeat (4) @(posedge clk);
    end

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    chk("scoreboard drained", 8'(sb_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
